sdram_wide_port: RTL and testbench
==================================

Name: sdram_wide_port

Overview:
- Responder end of the 128-bit arbiter request bus (ar_*).
- Accepts one 128-bit word read or write at a 22-bit word address.
- Splits each request into 16-bit beats on an Avalon-MM master port that drives the SDRAM controller. Reads are reassembled into 128 bits before return.
- Completion is signalled by a one-cycle ar_ac pulse. Sits between the frame/asset arbiter and the SDRAM controller IP.

Parameters:
- BEATS, 8, 16-bit beats per 128-bit word; fixed at 8, other values unsupported.
- MAX_PEND, 8, maximum outstanding Avalon reads (1..8).
- TIMEOUT, 4095, cycles a transaction may run before it is aborted and err is set.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ar_addr  in  22  128-bit word address
- ar_be  in  16  byte enables, bit i covers ar_wrdata[8i+7:8i]; writes only
- ar_read  in  1  read request, held until ar_ac
- ar_write  in  1  write request, held until ar_ac
- ar_wrdata  in  128  write data
- ar_ac  out  1  one-cycle completion pulse
- ar_rddata  out  128  assembled read data, valid in the ar_ac cycle and held until the next read completes
- av_address  out  25  halfword address, equal to {addr_q, beat[2:0]}
- av_byteenable  out  2  be_q[2b+1:2b] for beat b
- av_read  out  1  Avalon read
- av_write  out  1  Avalon write
- av_writedata  out  16  wrdata_q[16b+15:16b]
- av_readdata  in  16  Avalon read data
- av_readdatavalid  in  1  read data strobe
- av_waitrequest  in  1  stall; current command is held while high
- busy  out  1  high in every state except IDLE
- err  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset values:
  - State is IDLE.
  - ar_ac, av_read, av_write, busy and err are 0.
  - av_address, av_byteenable, av_writedata and ar_rddata are 0.
  - Beat, issue, return and pending counters are 0.
  - Reset mid-transaction aborts immediately: no ar_ac is produced, and av_read/av_write drop in the next cycle.
- States: IDLE, WR, RD, RD_DRAIN, ACK.
- IDLE:
  - Samples ar_read and ar_write every cycle.
  - On a request, latches addr_q, be_q and wrdata_q.
  - ar_write has priority over ar_read when both are high. ar_write goes to WR, ar_read goes to RD.
  - Request inputs are ignored outside IDLE.
- WR:
  - Beats are 0..7 in ascending order.
  - Beats with be_q pair equal to 00 are skipped and never issued.
  - A beat is issued while av_write=1. It advances when av_waitrequest=0 in that cycle.
  - After the last enabled beat is accepted, go to ACK.
  - ar_be=0 (no enabled beats) goes straight from WR to ACK without any Avalon access.
- RD:
  - Issues all 8 reads with av_byteenable=11. ar_be is ignored.
  - The issue counter advances on av_read & ~av_waitrequest.
  - Issue pauses (av_read=0) while pending==MAX_PEND.
  - Each av_readdatavalid writes av_readdata into slot ret_cnt (bits 16r+15:16r) and increments ret_cnt.
  - pending increments on each accepted read and decrements on each readdatavalid. Simultaneous issue and return leaves it unchanged.
  - After the 8th issue, go to RD_DRAIN.
- RD_DRAIN:
  - Waits for ret_cnt==8. ar_rddata is updated from the assembly register no later than the ACK cycle.
  - A readdatavalid arriving while pending==0, or in any non-read state, is ignored.
- ACK:
  - ar_ac=1 for exactly one cycle, then go to IDLE.
  - A request still high in the cycle after ACK is treated as a new request.
- Latency with no waitrequest:
  - Full write: request sampled at cycle T, av_write high T+1..T+8, ar_ac at T+9.
  - Read with Avalon read latency L: av_read high T+1..T+8, last readdatavalid at T+8+L, ar_ac at T+9+L.
- Timeout:
  - A cycle counter is cleared on entering WR or RD.
  - Reaching TIMEOUT in WR, RD or RD_DRAIN sets err, drops av_read/av_write and returns to IDLE with no ar_ac.
- busy = (state != IDLE).

Test Plan:
- Write, all bytes enabled: ar_write=1, ar_addr=22'h000010, ar_be=FFFF, ar_wrdata=128'h0007_0006_..._0000, no waitrequest.
  - Expect 8 Avalon writes to av_address 0x80..0x87 with data 0x0000..0x0007, byteenable 11.
  - Expect ar_ac exactly at T+9, one cycle wide.
- Write, partial enables: ar_be=16'h00C3.
  - Expect only beat 0 (be 11, addr base+0) and beat 3 (be 11, addr base+3) issued, then ar_ac.
  - ar_be=0: ar_ac at T+2 with no av_write.
- Read with latency 2: memory holds halfwords 0xA0..0xA7 at base 0x28 (ar_addr=5).
  - Expect ar_rddata=128'h00A7_00A6_..._00A0 in the ar_ac cycle, ar_ac at T+11.
- Waitrequest stalls: av_waitrequest high for 3 cycles on beat 2 of a write.
  - Expect address, data and byteenable held unchanged during the stall, no skipped or duplicated beats, ar_ac delayed by exactly 3 cycles.
- Simultaneous requests and back-to-back: ar_read=ar_write=1.
  - Expect the write serviced first; the read held high then completes as the next transaction.
  - With MAX_PEND=2 and latency 4, expect at most 2 outstanding reads at any time.
- Reset and timeout:
  - Reset asserted after 3 reads are issued: expect no ar_ac, state IDLE; 3 stray readdatavalids afterwards are ignored; the next read returns correct data.
  - Readdatavalid withheld with TIMEOUT=20: expect err=1 and return to IDLE.

Source files
------------

// File: rtl/sdram_wide_port.sv
// Bridges one 128-bit arbiter request (ar_*) onto a 16-bit Avalon-MM master port.
// Writes issue only byte-enabled beats; reads keep up to MAX_PEND beats in flight and reassemble 128 bits.
module sdram_wide_port #(
  parameter int BEATS    = 8,
  parameter int MAX_PEND = 8,
  parameter int TIMEOUT  = 4095
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [21:0]  ar_addr,
  input  logic [15:0]  ar_be,
  input  logic         ar_read,
  input  logic         ar_write,
  input  logic [127:0] ar_wrdata,
  output logic         ar_ac,
  output logic [127:0] ar_rddata,
  output logic [24:0]  av_address,
  output logic [1:0]   av_byteenable,
  output logic         av_read,
  output logic         av_write,
  output logic [15:0]  av_writedata,
  input  logic [15:0]  av_readdata,
  input  logic         av_readdatavalid,
  input  logic         av_waitrequest,
  output logic         busy,
  output logic         err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_DRAIN, ACK} state_t;

  state_t         state_q, state_d;
  logic [21:0]    addr_q, addr_d;
  logic [15:0]    be_q, be_d;
  logic [127:0]   wrdata_q, wrdata_d;
  logic [7:0]     mask_q, mask_d;    // enabled write beats not yet accepted
  logic [2:0]     beat_q, beat_d;
  logic [3:0]     iss_q, iss_d;
  logic [3:0]     ret_q, ret_d;
  logic [3:0]     pend_q, pend_d;
  logic [127:0]   asm_q, asm_d;
  logic [127:0]   rddata_q, rddata_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           err_q, err_d;

  logic           tmo_hit;
  logic           rd_issue;
  logic           iss_fire;
  logic           rdv_fire;
  logic [7:0]     mask_nxt;

  function automatic logic [7:0] pair_mask(input logic [15:0] be);
    logic [7:0] m;
    for (int b = 0; b < 8; b++) m[b] = |be[2*b +: 2];
    return m;
  endfunction

  // Lowest set bit wins; an empty mask yields beat 0.
  function automatic logic [2:0] first_beat(input logic [7:0] m);
    logic [2:0] f;
    f = 3'd0;
    for (int b = 7; b >= 0; b--) if (m[b]) f = 3'(b);
    return f;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d       = state_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wrdata_d      = wrdata_q;
    mask_d        = mask_q;
    beat_d        = beat_q;
    iss_d         = iss_q;
    ret_d         = ret_q;
    asm_d         = asm_q;
    rddata_d      = rddata_q;
    tmo_d         = tmo_q;
    err_d         = err_q;
    mask_nxt      = mask_q;
    av_read       = 1'b0;
    av_write      = 1'b0;
    av_byteenable = 2'b00;

    tmo_hit  = (tmo_q == TW'(TIMEOUT));
    rd_issue = (state_q == RD) && !tmo_hit && (pend_q != 4'(MAX_PEND));
    iss_fire = rd_issue && !av_waitrequest;
    // Returns are only meaningful while a read is in flight; strays are dropped.
    rdv_fire = av_readdatavalid && (pend_q != 4'd0) &&
               ((state_q == RD) || (state_q == RD_DRAIN));

    if (rdv_fire) begin
      asm_d[{ret_q[2:0], 4'b0000} +: 16] = av_readdata;
      ret_d = ret_q + 4'd1;
    end
    pend_d = pend_q + {3'b000, iss_fire} - {3'b000, rdv_fire};

    case (state_q)
      IDLE: begin
        if (ar_write || ar_read) begin
          addr_d   = ar_addr;
          be_d     = ar_be;
          wrdata_d = ar_wrdata;
          tmo_d    = '0;
          if (ar_write) begin
            mask_d  = pair_mask(ar_be);
            beat_d  = first_beat(pair_mask(ar_be));
            state_d = WR;
          end else begin
            beat_d  = 3'd0;
            iss_d   = 4'd0;
            ret_d   = 4'd0;
            pend_d  = 4'd0;
            state_d = RD;
          end
        end
      end
      WR: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (mask_q == 8'd0) begin
          state_d = ACK;
        end else begin
          av_write      = 1'b1;
          av_byteenable = be_q[{beat_q, 1'b0} +: 2];
          if (!av_waitrequest) begin
            mask_nxt = mask_q & ~(8'b1 << beat_q);
            mask_d   = mask_nxt;
            if (mask_nxt == 8'd0) state_d = ACK;
            else                  beat_d  = first_beat(mask_nxt);
          end
        end
      end
      RD: begin
        tmo_d         = tmo_q + TW'(1);
        av_read       = rd_issue;
        av_byteenable = 2'b11;
        if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (iss_fire) begin
          iss_d = iss_q + 4'd1;
          if (iss_q == 4'(BEATS - 1)) begin
            // A zero-latency slave can complete the word in the last issue cycle.
            if (ret_d == 4'(BEATS)) begin
              rddata_d = asm_d;
              state_d  = ACK;
            end else begin
              state_d = RD_DRAIN;
            end
          end
        end
      end
      RD_DRAIN: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (ret_d == 4'(BEATS)) begin
          rddata_d = asm_d;
          state_d  = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset as well, so the Avalon outputs read 0 straight after reset.
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      be_q     <= '0;
      wrdata_q <= '0;
      mask_q   <= '0;
      beat_q   <= '0;
      iss_q    <= '0;
      ret_q    <= '0;
      pend_q   <= '0;
      asm_q    <= '0;
      rddata_q <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wrdata_q <= wrdata_d;
      mask_q   <= mask_d;
      beat_q   <= beat_d;
      iss_q    <= iss_d;
      ret_q    <= ret_d;
      pend_q   <= pend_d;
      asm_q    <= asm_d;
      rddata_q <= rddata_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

  assign av_address   = {addr_q, (state_q == RD) ? iss_q[2:0] : beat_q};
  assign av_writedata = wrdata_q[{beat_q, 4'b0000} +: 16];
  assign ar_ac        = (state_q == ACK);
  assign ar_rddata    = rddata_q;
  assign busy         = (state_q != IDLE);
  assign err          = err_q;

endmodule

// File: tb/tb_sdram_wide_port.sv
// Directed bench for sdram_wide_port: one instance (MAX_PEND=8, TIMEOUT=20) for most steps,
// a second (MAX_PEND=2) for the outstanding-read limit, sharing a small Avalon slave model.
module tb_sdram_wide_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         sel;
  logic [21:0]  ar_addr;
  logic [15:0]  ar_be;
  logic         ar_read;
  logic         ar_write;
  logic [127:0] ar_wrdata;
  logic [15:0]  av_readdata;
  logic         av_readdatavalid;
  logic         av_waitrequest;

  logic         a_ac, a_read, a_write, a_busy, a_err;
  logic [127:0] a_rddata;
  logic [24:0]  a_address;
  logic [1:0]   a_be;
  logic [15:0]  a_wdata;
  logic         b_ac, b_read, b_write, b_busy, b_err;
  logic [127:0] b_rddata;
  logic [24:0]  b_address;
  logic [1:0]   b_be;
  logic [15:0]  b_wdata;

  logic a_req_rd, a_req_wr, b_req_rd, b_req_wr;
  assign a_req_rd = ar_read  & ~sel;
  assign a_req_wr = ar_write & ~sel;
  assign b_req_rd = ar_read  &  sel;
  assign b_req_wr = ar_write &  sel;

  sdram_wide_port #(.BEATS(8), .MAX_PEND(8), .TIMEOUT(20)) u_dut_a (
    .clk(clk), .reset(reset), .ar_addr(ar_addr), .ar_be(ar_be),
    .ar_read(a_req_rd), .ar_write(a_req_wr), .ar_wrdata(ar_wrdata),
    .ar_ac(a_ac), .ar_rddata(a_rddata), .av_address(a_address),
    .av_byteenable(a_be), .av_read(a_read), .av_write(a_write),
    .av_writedata(a_wdata), .av_readdata(av_readdata),
    .av_readdatavalid(av_readdatavalid), .av_waitrequest(av_waitrequest),
    .busy(a_busy), .err(a_err)
  );

  sdram_wide_port #(.BEATS(8), .MAX_PEND(2), .TIMEOUT(4095)) u_dut_b (
    .clk(clk), .reset(reset), .ar_addr(ar_addr), .ar_be(ar_be),
    .ar_read(b_req_rd), .ar_write(b_req_wr), .ar_wrdata(ar_wrdata),
    .ar_ac(b_ac), .ar_rddata(b_rddata), .av_address(b_address),
    .av_byteenable(b_be), .av_read(b_read), .av_write(b_write),
    .av_writedata(b_wdata), .av_readdata(av_readdata),
    .av_readdatavalid(av_readdatavalid), .av_waitrequest(av_waitrequest),
    .busy(b_busy), .err(b_err)
  );

  logic         m_ac, m_read, m_write;
  logic [127:0] m_rddata;
  logic [24:0]  m_addr;
  logic [1:0]   m_be;
  logic [15:0]  m_wdata;
  assign m_ac     = sel ? b_ac      : a_ac;
  assign m_read   = sel ? b_read    : a_read;
  assign m_write  = sel ? b_write   : a_write;
  assign m_rddata = sel ? b_rddata  : a_rddata;
  assign m_addr   = sel ? b_address : a_address;
  assign m_be     = sel ? b_be      : a_be;
  assign m_wdata  = sel ? b_wdata   : a_wdata;

  // Slave model: fixed read latency `lat`, optional return withholding, stall on beat 2 of writes.
  int           lat;
  int           stall_until;
  logic         withhold;
  logic         stray;
  logic [15:0]  mem [0:255];
  logic [255:0] mem_v = '0;
  logic [16:1]  pv = '0;
  logic [24:0]  pa [1:16];
  logic [42:0]  wlog [0:63];
  logic [42:0]  slog [0:15];
  int           wr_n = 0;
  int           st_n = 0;
  int           rd_acc_n = 0;
  int           pend = 0;
  int           max_pend = 0;

  // Unwritten locations read back as 0x00A0 + (addr - 0x28).
  function automatic logic [15:0] mem_rd(input logic [7:0] a);
    return mem_v[a] ? mem[a] : {8'h00, a + 8'h78};
  endfunction

  assign av_waitrequest   = m_write && (m_addr[2:0] == 3'd2) && (st_n < stall_until);
  assign av_readdatavalid = pv[1] | stray;
  assign av_readdata      = stray ? 16'hDEAD : mem_rd(pa[1][7:0]);

  always @(posedge clk) begin
    pv <= {1'b0, pv[16:2]};
    for (int i = 1; i < 16; i++) pa[i] <= pa[i+1];
    if (m_read && !av_waitrequest && !withhold) begin
      pv[lat] <= 1'b1;
      pa[lat] <= m_addr;
    end
    if (m_read && !av_waitrequest) rd_acc_n <= rd_acc_n + 1;
    if (m_write && !av_waitrequest) begin
      wlog[wr_n[5:0]]     <= {m_addr, m_wdata, m_be};
      wr_n                <= wr_n + 1;
      mem[m_addr[7:0]]    <= m_wdata;
      mem_v[m_addr[7:0]]  <= 1'b1;
    end
    if (m_write && av_waitrequest) begin
      slog[st_n[3:0]] <= {m_addr, m_wdata, m_be};
      st_n            <= st_n + 1;
    end
    if (sel) pend <= pend + int'(m_read && !av_waitrequest) - int'(av_readdatavalid);
    if (pend > max_pend) max_pend <= pend;
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // n = 1 is the cycle after the request was first presented; -1 if no ar_ac within budget.
  task automatic wait_ac(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (m_ac) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int   n;
    int   base;
    int   sbase;
    int   rbase;
    logic seen;

    reset = 1'b1; sel = 1'b0; ar_addr = '0; ar_be = '0; ar_read = 1'b0; ar_write = 1'b0;
    ar_wrdata = '0; lat = 2; withhold = 1'b0; stray = 1'b0; stall_until = 0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {a_ac, a_read, a_write, a_busy, a_err, a_be}, '0);
    chk("reset_av", {a_address, a_wdata}, '0);
    chk("reset_rddata", a_rddata, '0);
    reset = 1'b0;
    @(negedge clk);

    // Full write
    base = wr_n;
    ar_addr = 22'h000010; ar_be = 16'hFFFF;
    ar_wrdata = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    ar_write = 1'b1;
    wait_ac(40, n);
    ar_write = 1'b0;
    chk("wr_full_latency", n, 9);
    chk("wr_full_count", wr_n - base, 8);
    for (int i = 0; i < 8; i++)
      chk("wr_full_beat", wlog[base+i], {25'(32'h80 + i), 16'(i), 2'b11});
    @(negedge clk);
    chk("wr_full_ac_width", a_ac, 1'b0);

    // Partial enables: only beats 0 and 3
    base = wr_n;
    ar_be = 16'h00C3; ar_write = 1'b1;
    wait_ac(40, n);
    ar_write = 1'b0;
    chk("wr_part_latency", n, 3);
    chk("wr_part_count", wr_n - base, 2);
    chk("wr_part_beat0", wlog[base], {25'h80, 16'h0000, 2'b11});
    chk("wr_part_beat3", wlog[base+1], {25'h83, 16'h0003, 2'b11});
    @(negedge clk);

    // No enabled bytes
    base = wr_n;
    ar_be = 16'h0000; ar_write = 1'b1;
    wait_ac(40, n);
    ar_write = 1'b0;
    chk("wr_none_latency", n, 2);
    chk("wr_none_count", wr_n - base, 0);
    @(negedge clk);

    // Read, latency 2
    lat = 2; ar_addr = 22'd5; ar_read = 1'b1;
    wait_ac(40, n);
    ar_read = 1'b0;
    chk("rd_latency", n, 11);
    chk("rd_data", a_rddata, 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0);
    @(negedge clk);
    chk("rd_data_held", a_rddata, 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0);

    // Write with 3-cycle stall on beat 2
    base = wr_n; sbase = st_n; stall_until = st_n + 3;
    ar_addr = 22'h000010; ar_be = 16'hFFFF;
    ar_wrdata = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    ar_write = 1'b1;
    wait_ac(40, n);
    ar_write = 1'b0;
    chk("stall_latency", n, 12);
    chk("stall_count", wr_n - base, 8);
    for (int i = 0; i < 8; i++)
      chk("stall_beat", wlog[base+i], {25'(32'h80 + i), 16'(i), 2'b11});
    chk("stall_cycles", st_n - sbase, 3);
    for (int i = 0; i < 3; i++)
      chk("stall_hold", slog[sbase+i], {25'h82, 16'h0002, 2'b11});
    @(negedge clk);

    // Simultaneous write+read: write first, held read follows
    base = wr_n; rbase = rd_acc_n;
    ar_addr = 22'd3; ar_be = 16'hFFFF;
    ar_wrdata = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    ar_write = 1'b1; ar_read = 1'b1;
    wait_ac(40, n);
    ar_write = 1'b0;
    chk("both_wr_latency", n, 9);
    chk("both_wr_count", wr_n - base, 8);
    chk("both_no_read_yet", rd_acc_n - rbase, 0);
    wait_ac(40, n);
    ar_read = 1'b0;
    chk("both_rd_latency", n, 12);
    chk("both_rd_data", a_rddata, 128'h7777_6666_5555_4444_3333_2222_1111_0000);
    @(negedge clk);

    // Reset after 3 reads issued
    withhold = 1'b1; rbase = rd_acc_n;
    ar_addr = 22'd5; ar_read = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_acc_n - rbase >= 3) break;
    end
    chk("rst_reads_issued", 128'(rd_acc_n - rbase >= 3), 1);
    reset = 1'b1; ar_read = 1'b0;
    @(negedge clk);
    chk("rst_abort", {a_busy, a_read, a_ac}, '0);
    reset = 1'b0;
    seen = 1'b0;
    stray = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen = seen | a_ac | a_busy;
    end
    stray = 1'b0;
    chk("rst_stray_ignored", seen, 1'b0);
    withhold = 1'b0;
    ar_read = 1'b1;
    wait_ac(40, n);
    ar_read = 1'b0;
    chk("rst_next_latency", n, 11);
    chk("rst_next_data", a_rddata, 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0);
    @(negedge clk);

    // Timeout with returns withheld
    chk("tmo_err_before", a_err, 1'b0);
    withhold = 1'b1; seen = 1'b0; n = -1;
    ar_read = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      seen = seen | a_ac;
      if (!a_busy) begin
        n = i;
        break;
      end
    end
    ar_read = 1'b0;
    chk("tmo_err", a_err, 1'b1);
    chk("tmo_no_ac", seen, 1'b0);
    chk("tmo_window", 128'(n >= 20 && n <= 24), 1);
    @(negedge clk);
    withhold = 1'b0;
    chk("tmo_idle", a_busy, 1'b0);

    // MAX_PEND=2 instance, latency 4
    sel = 1'b1; lat = 4;
    @(negedge clk);
    ar_addr = 22'd5; ar_read = 1'b1;
    wait_ac(80, n);
    ar_read = 1'b0;
    chk("pend_done", 128'(n > 0), 1);
    chk("pend_data", m_rddata, 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0);
    @(negedge clk);
    chk("pend_max", max_pend, 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
